// File: rtl/exe_cmd_decoder_pkg.sv
// exe_cmd_decoder_pkg: opcodes, ALU command codes, branch encoding and the decoded bundle type.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (used by opcode_decode and exe_cmd_decoder).
package exe_cmd_decoder_pkg;
   localparam logic [5:0] OP_NOP = 6'd0, OP_ADD = 6'd1, OP_SUB = 6'd3, OP_AND = 6'd5,
                          OP_OR = 6'd6, OP_NOR = 6'd7, OP_XOR = 6'd8, OP_SLA = 6'd9,
                          OP_SLL = 6'd10, OP_SRA = 6'd11, OP_SRL = 6'd12, OP_ADDI = 6'd32,
                          OP_SUBI = 6'd33, OP_LD = 6'd36, OP_ST = 6'd37, OP_BEZ = 6'd40,
                          OP_BNE = 6'd41, OP_JMP = 6'd42;
   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0010, ALU_AND = 4'b0100,
                          ALU_OR = 4'b0101, ALU_NOR = 4'b0110, ALU_XOR = 4'b0111,
                          ALU_SHL = 4'b1000, ALU_SRA = 4'b1001, ALU_SRL = 4'b1010;
   // control groups packed as {wb_en, mem_r_en, mem_w_en, is_imm}
   localparam logic [3:0] CTL_R = 4'b1000, CTL_I = 4'b1001, CTL_LD = 4'b1101, CTL_ST = 4'b0011;
   typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEZ = 2'b01, BR_BNE = 2'b10, BR_JMP = 2'b11} br_type_e;
   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       wb_en;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       is_imm;
      br_type_e   br_type;
      logic       illegal;
   } bundle_t;
   typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
endpackage

// File: rtl/exe_cmd_decoder_opcode_decode.sv
// opcode_decode: combinational opcode -> bundle decoder.
// Ports: instr (in, INSTR_W) fetched instruction; bundle (out, bundle_t) decoded controls.
// ILLEGAL_OP_TRAP_EN: unknown opcodes flag illegal; otherwise they decode as NOP.
module opcode_decode import exe_cmd_decoder_pkg::*; #(
   parameter int INSTR_W = 32
) (
   input  logic [INSTR_W-1:0] instr,
   output bundle_t            bundle
);
`ifdef ILLEGAL_OP_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif
   logic [5:0] op;
   logic [3:0] cmd;
   logic [3:0] ctl;
   br_type_e   br;
   logic       ill;
   logic       unused_bits;
   assign op = instr[INSTR_W-1:INSTR_W-6];
   assign unused_bits = ^instr[INSTR_W-7:0];
   always_comb begin
      cmd = ALU_ADD;
      ctl = '0;
      br = BR_NONE;
      ill = 1'b0;
      case (op)
         OP_NOP:  ;
         OP_ADD:  ctl = CTL_R;
         OP_SUB:  {cmd, ctl} = {ALU_SUB, CTL_R};
         OP_AND:  {cmd, ctl} = {ALU_AND, CTL_R};
         OP_OR:   {cmd, ctl} = {ALU_OR, CTL_R};
         OP_NOR:  {cmd, ctl} = {ALU_NOR, CTL_R};
         OP_XOR:  {cmd, ctl} = {ALU_XOR, CTL_R};
         OP_SLA, OP_SLL: {cmd, ctl} = {ALU_SHL, CTL_R};
         OP_SRA:  {cmd, ctl} = {ALU_SRA, CTL_R};
         OP_SRL:  {cmd, ctl} = {ALU_SRL, CTL_R};
         OP_ADDI: ctl = CTL_I;
         OP_SUBI: {cmd, ctl} = {ALU_SUB, CTL_I};
         OP_LD:   ctl = CTL_LD;
         OP_ST:   ctl = CTL_ST;
         OP_BEZ:  br = BR_BEZ;
         OP_BNE:  br = BR_BNE;
         OP_JMP:  br = BR_JMP;
         default: ill = TRAP;
      endcase
   end
   assign bundle = '{exe_cmd: cmd, wb_en: ctl[3], mem_r_en: ctl[2], mem_w_en: ctl[1],
                     is_imm: ctl[0], br_type: br, illegal: ill};
endmodule

// File: rtl/exe_cmd_decoder.sv
// exe_cmd_decoder: instruction decoder feeding a 2-entry skid buffer toward execute.
// Ports: clk, rst (async active-low); in_valid/in_ready/instr upstream; flush;
// out_valid/out_ready downstream; exe_cmd, wb_en, mem_r_en, mem_w_en, is_imm, br_type, illegal.
// ILLEGAL_OP_TRAP_EN adds illegal_cnt (16-bit saturating count of accepted illegal opcodes).
module exe_cmd_decoder import exe_cmd_decoder_pkg::*; #(
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         exe_cmd,
   output logic               wb_en,
   output logic               mem_r_en,
   output logic               mem_w_en,
   output logic               is_imm,
   output logic [1:0]         br_type,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic [15:0]        illegal_cnt,
`endif
   output logic               illegal
);
   buf_state_e state_q, state_d;
   bundle_t    b0_q, b0_d, b1_q, b1_d, dec;
   logic       in_ready_q, in_ready_d, acc, pop;
   opcode_decode #(.INSTR_W(INSTR_W)) u_dec (.instr(instr), .bundle(dec));
   assign acc = in_valid && in_ready_q;
   assign pop = out_valid && out_ready;
   // b0 is always the oldest entry; b1 only holds data in FULL
   always_comb begin
      state_d = state_q;
      b0_d = b0_q;
      b1_d = b1_q;
      case (state_q)
         EMPTY: if (acc) {b0_d, state_d} = {dec, ONE};
         ONE:   if (acc && pop) b0_d = dec;
                else if (acc) {b1_d, state_d} = {dec, FULL};
                else if (pop) state_d = EMPTY;
         FULL:  if (pop) {b0_d, state_d} = {b1_q, ONE};
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
      in_ready_d = state_d != FULL;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         in_ready_q <= 1'b0;
         b0_q <= '0;
         b1_q <= '0;
      end else begin
         state_q <= state_d;
         in_ready_q <= in_ready_d;
         b0_q <= b0_d;
         b1_q <= b1_d;
      end
   end
`ifdef ILLEGAL_OP_TRAP_EN
   logic [15:0] cnt_q, cnt_d;
   assign cnt_d = (acc && !flush && dec.illegal && cnt_q != 16'hffff) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign illegal_cnt = cnt_q;
`endif
   assign in_ready = in_ready_q;
   assign out_valid = state_q != EMPTY;
   assign exe_cmd = b0_q.exe_cmd;
   assign wb_en = b0_q.wb_en;
   assign mem_r_en = b0_q.mem_r_en;
   assign mem_w_en = b0_q.mem_w_en;
   assign is_imm = b0_q.is_imm;
   assign br_type = b0_q.br_type;
   assign illegal = b0_q.illegal;
endmodule

// File: doc/exe_cmd_decoder.md
EXE_CMD_DECODER -- requirements
Module: exe_cmd_decoder

Interface
REQ-001 Parameter INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-6].
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  upstream instruction valid.
REQ-005 in_ready  out  1  decoder can accept an instruction this cycle.
REQ-006 instr  in  INSTR_W  fetched instruction.
REQ-007 flush  in  1  discard all buffered instructions.
REQ-008 out_valid  out  1  decoded bundle valid.
REQ-009 out_ready  in  1  execute stage accepts the bundle.
REQ-010 exe_cmd  out  4  ALU command.
REQ-011 wb_en, mem_r_en, mem_w_en, is_imm  out  1 each  writeback, load, store and immediate-operand controls.
REQ-012 br_type  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
REQ-013 illegal  out  1  bundle came from an unrecognised opcode.

Function
REQ-014 Opcode to exe_cmd mapping: NOP 0 -> 0000 with all enables 0; ADD 1 -> 0000; SUB 3 -> 0010; AND 5 -> 0100; OR 6 -> 0101; NOR 7 -> 0110; XOR 8 -> 0111; SLA 9 and SLL 10 -> 1000; SRA 11 -> 1001; SRL 12 -> 1010.
REQ-015 Register-type opcodes 1-12 set wb_en=1 and is_imm=0.
REQ-016 ADDI 32 -> 0000 and SUBI 33 -> 0010, each with wb_en=1 and is_imm=1.
REQ-017 LD 36 -> 0000 with wb_en=1, mem_r_en=1, is_imm=1.
REQ-018 ST 37 -> 0000 with mem_w_en=1, is_imm=1.
REQ-019 BEZ 40, BNE 41 and JMP 42 set br_type per REQ-012, exe_cmd=0000 and all enables 0.
REQ-020 Opcodes not listed are illegal; their handling is defined in Configuration.
REQ-021 Decoding is combinational on instr; the result is captured into a 2-entry skid buffer; latency is 1 cycle from in_valid&&in_ready to out_valid.
REQ-022 The buffer FSM has states EMPTY, ONE and FULL.
- EMPTY -> ONE on accept.
- ONE stays ONE on accept with pop, -> FULL on accept without pop, -> EMPTY on pop without accept.
- FULL -> ONE on pop.
REQ-023 in_ready = (state != FULL), registered and glitch-free; a transfer occurs only on valid&&ready.
REQ-024 Output fields are held stable while out_valid=1 and out_ready=0.
REQ-025 Order is preserved: the oldest entry is always presented first.
REQ-026 flush has priority over every simultaneous event: next state EMPTY, out_valid=0, and any same-cycle input is dropped.

Reset
REQ-027 While rst=0: state EMPTY, out_valid=0, in_ready=0, all bundle outputs 0.
REQ-028 in_ready rises in the first cycle after rst deasserts.
REQ-029 Reset asserted mid-transfer discards all entries with no partial output.

Configuration
REQ-030 With ILLEGAL_OP_TRAP_EN defined:
- an illegal opcode yields a bundle with illegal=1 and all enables 0;
- a 16-bit saturating counter illegal_cnt (extra output port) increments per accepted illegal instruction and clears on reset.
REQ-031 Without ILLEGAL_OP_TRAP_EN: illegal opcodes decode as NOP, illegal is tied to 0, and no counter or extra port exists.

Structure
REQ-032 A shared package holds:
- opcode constants;
- 4-bit ALU command constants, matching the ALU encoding exactly;
- the br_type encoding;
- the decoded-bundle struct typedef.
REQ-033 The combinational decoder is a sub-module, opcode_decode; the buffer/FSM stays in the top module.

Verification
REQ-034 After reset, in_valid=1 with opcode 3 and out_ready=1 -> next cycle out_valid=1, exe_cmd=0010, wb_en=1.
REQ-035 out_ready=0 while sending ADD then LD -> in_ready=0 after the 2nd accept; releasing out_ready yields 0000/wb then LD with mem_r_en=1, in order.
REQ-036 flush while FULL together with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted later.
REQ-037 Opcode 63 -> with macro: illegal=1 and illegal_cnt=1; without macro: NOP bundle with illegal=0.
REQ-038 rst driven to 0 in state ONE -> out_valid=0 asynchronously, before the next clock edge.
REQ-039 Opcodes 9, 10, 11, 12, 41 in sequence -> exe_cmd 1000, 1000, 1001, 1010, 0000 with br_type=10 on the last.
